rect_draw_engine: RTL and testbench

Framebuffer pixel writer that draws an axis-aligned rectangle, filled or outline-only, with a programmable colour. It writes into the write port of the VGA frame memory. It generalises the fixed 10-pixel vertical-line drawer: origin, width, height, colour and mode are all runtime inputs, and screen geometry and widths are parameters. Screen-edge clipping and a start/busy/done handshake are added so a game-logic sequencer can queue draw commands.

---
 rtl/draw_pkg.sv | 21 ++
 rtl/rect_clip.sv | 32 +++
 rtl/rect_draw_engine.sv | 153 +++++++++++++++
 tb/tb_rect_draw_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Screen geometry, widths, FSM states and mode constants shared by the
// framebuffer draw engines (rectangles, sprites, lines).
package draw_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;
  localparam int COLOR_W  = 3;
  localparam int DIM_W    = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    DRAW   = 2'd2,
    FINISH = 2'd3
  } draw_state_t;

  localparam logic MODE_FILL    = 1'b0;
  localparam logic MODE_OUTLINE = 1'b1;

endpackage

// File: rtl/rect_clip.sv
// Clips a rectangle against the screen: exclusive end column/row (one bit
// wider than the inputs so x+w cannot overflow) and a nothing-to-draw flag.
module rect_clip #(
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H,
  parameter int DIM_W    = draw_pkg::DIM_W
) (
  input  logic [DIM_W-1:0] x,
  input  logic [DIM_W-1:0] y,
  input  logic [DIM_W-1:0] rect_w,
  input  logic [DIM_W-1:0] rect_h,
  output logic [DIM_W:0]   x_end,
  output logic [DIM_W:0]   y_end,
  output logic             empty
);

  localparam logic [DIM_W:0] SW = (DIM_W+1)'(SCREEN_W);
  localparam logic [DIM_W:0] SH = (DIM_W+1)'(SCREEN_H);

  logic [DIM_W:0] x_sum;
  logic [DIM_W:0] y_sum;

  assign x_sum = {1'b0, x} + {1'b0, rect_w};
  assign y_sum = {1'b0, y} + {1'b0, rect_h};

  assign x_end = (x_sum > SW) ? SW : x_sum;
  assign y_end = (y_sum > SH) ? SH : y_sum;

  assign empty = (rect_w == '0) || (rect_h == '0) ||
                 ({1'b0, x} >= SW) || ({1'b0, y} >= SH);

endmodule

// File: rtl/rect_draw_engine.sv
// Draws a filled or outline rectangle into the frame memory write port,
// one pixel per cycle, clipped to the screen, with a start/busy/done handshake.
module rect_draw_engine #(
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H,
  parameter int ADDR_W   = draw_pkg::ADDR_W,
  parameter int COLOR_W  = draw_pkg::COLOR_W,
  parameter int DIM_W    = draw_pkg::DIM_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [DIM_W-1:0]   x,
  input  logic [DIM_W-1:0]   y,
  input  logic [DIM_W-1:0]   rect_w,
  input  logic [DIM_W-1:0]   rect_h,
  input  logic [COLOR_W-1:0] color,
  input  logic               mode,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_waddr,
  output logic [COLOR_W-1:0] mem_wdata,
  output logic               mem_wenable
);
  import draw_pkg::*;

  localparam logic [ADDR_W-1:0] SW_ADDR = ADDR_W'(SCREEN_W);
  localparam logic [31:0]       SW_BITS = 32'(SCREEN_W);
  localparam logic [DIM_W:0]    ONE     = (DIM_W+1)'(1);

  draw_state_t state_q, next_state;

  logic [DIM_W-1:0]   x_r, y_r, w_r, h_r;
  logic [COLOR_W-1:0] color_r;
  logic               mode_r;
  logic [DIM_W:0]     x_end_q, y_end_q, col_q, row_q;
  logic [ADDR_W-1:0]  row_base_q;

  logic [DIM_W:0]     clip_x_end, clip_y_end;
  logic               clip_empty;
  logic [ADDR_W-1:0]  row_base_init, pixel_addr;
  logic [DIM_W:0]     x_ext, y_ext, bottom_row, col_step, row_step;
  logic               outline, middle_row, jump, row_wrap, last_row;

  rect_clip #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .DIM_W   (DIM_W)
  ) u_clip (
    .x     (x_r),
    .y     (y_r),
    .rect_w(w_r),
    .rect_h(h_r),
    .x_end (clip_x_end),
    .y_end (clip_y_end),
    .empty (clip_empty)
  );

  // y*SCREEN_W as a sum of shifted copies of y, one per set bit of the stride
  always_comb begin
    row_base_init = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      if (SW_BITS[b]) row_base_init = row_base_init + (ADDR_W'(y_r) << b);
    end
  end

  // Outline middle rows visit only the left column and the unclipped right column
  assign x_ext      = {1'b0, x_r};
  assign y_ext      = {1'b0, y_r};
  assign bottom_row = y_ext + {1'b0, h_r} - ONE;
  assign outline    = (mode_r != MODE_FILL);
  assign middle_row = outline && (row_q != y_ext) && (row_q != bottom_row);
  assign jump       = middle_row && (col_q == x_ext) && (w_r > DIM_W'(1));
  assign col_step   = jump ? (x_ext + {1'b0, w_r} - ONE) : (col_q + ONE);
  assign row_step   = row_q + ONE;
  assign row_wrap   = (col_step >= x_end_q);
  assign last_row   = (row_step >= y_end_q);
  assign pixel_addr = row_base_q + ADDR_W'(col_q);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= next_state;
  end

  always_comb begin
    next_state = state_q;
    case (state_q)
      IDLE:    if (start) next_state = SETUP;
      SETUP:   next_state = clip_empty ? FINISH : DRAW;
      DRAW:    if (row_wrap && last_row) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_wenable <= 1'b0;
      mem_waddr   <= '0;
      mem_wdata   <= '0;
      x_r         <= '0;
      y_r         <= '0;
      w_r         <= '0;
      h_r         <= '0;
      color_r     <= '0;
      mode_r      <= 1'b0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      row_base_q  <= '0;
    end else begin
      busy        <= (next_state != IDLE);
      done        <= (state_q == FINISH);
      mem_wenable <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_r     <= x;
            y_r     <= y;
            w_r     <= rect_w;
            h_r     <= rect_h;
            color_r <= color;
            mode_r  <= mode;
          end
        end
        SETUP: begin
          x_end_q    <= clip_x_end;
          y_end_q    <= clip_y_end;
          row_base_q <= row_base_init;
          col_q      <= x_ext;
          row_q      <= y_ext;
        end
        DRAW: begin
          mem_wenable <= 1'b1;
          mem_waddr   <= pixel_addr;
          mem_wdata   <= color_r;
          if (row_wrap) begin
            col_q      <= x_ext;
            row_q      <= row_step;
            row_base_q <= row_base_q + SW_ADDR;
          end else begin
            col_q <= col_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: a negedge monitor logs every write and
// done pulse, and each test task compares the log with hand-computed values.
module tb_rect_draw_engine;
  import draw_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [DIM_W-1:0]   x = '0, y = '0, rect_w = '0, rect_h = '0;
  logic [COLOR_W-1:0] color = '0;
  logic               mode = 1'b0;
  logic               busy, done, mem_wenable;
  logic [ADDR_W-1:0]  mem_waddr;
  logic [COLOR_W-1:0] mem_wdata;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  rect_draw_engine dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .x          (x),
    .y          (y),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .color      (color),
    .mode       (mode),
    .busy       (busy),
    .done       (done),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wenable(mem_wenable)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (mem_wenable === 1'b1) begin
      wr_addr.push_back(int'(mem_waddr));
      wr_data.push_back(int'(mem_wdata));
      wr_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_cnt = busy_cnt + 1;
  end

  // Called at a negedge; returns at the negedge just after the start edge (E0)
  task automatic apply_stimulus(input int cx, input int cy, input int cw, input int ch,
                                input int cc, input logic cm, output int s);
    x      = DIM_W'(cx);
    y      = DIM_W'(cy);
    rect_w = DIM_W'(cw);
    rect_h = DIM_W'(ch);
    color  = COLOR_W'(cc);
    mode   = cm;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    s      = cyc;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    done_cyc = 0;
    busy_cnt = 0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_timeout got no done in %0d cycles want done", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
    checks++; if (mem_wenable !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got %b want 0", mem_wenable); end
    checks++; if (mem_waddr !== '0) begin errors++; $display("[TB] FAIL reset_waddr got %0d want 0", mem_waddr); end
    checks++; if (mem_wdata !== '0) begin errors++; $display("[TB] FAIL reset_wdata got %0d want 0", mem_wdata); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", busy); end
  endtask

  task automatic test_filled();
    int s, got;
    int exp_a[4] = '{0, 1, 640, 641};
    clear_log();
    apply_stimulus(0, 0, 2, 2, 5, MODE_FILL, s);
    wait_done(40, "filled");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 4) begin errors++; $display("[TB] FAIL fill_count got %0d want 4", wr_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < wr_addr.size()) ? wr_addr[i] : -1;
      checks++; if (got != exp_a[i]) begin errors++; $display("[TB] FAIL fill_addr%0d got %0d want %0d", i, got, exp_a[i]); end
      got = (i < wr_data.size()) ? wr_data[i] : -1;
      checks++; if (got != 5) begin errors++; $display("[TB] FAIL fill_data%0d got %0d want 5", i, got); end
    end
    got = (wr_cyc.size() > 0) ? wr_cyc[0] - s : -1;
    checks++; if (got != 2) begin errors++; $display("[TB] FAIL fill_latency got %0d want 2", got); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL fill_done_count got %0d want 1", done_cnt); end
    checks++; if (done_cyc - s != 6) begin errors++; $display("[TB] FAIL fill_done_time got %0d want 6", done_cyc - s); end
    checks++; if (busy_cnt != 6) begin errors++; $display("[TB] FAIL fill_busy_cycles got %0d want 6", busy_cnt); end
  endtask

  task automatic test_outline();
    int s, got;
    int exp_a[10] = '{650, 651, 652, 653, 1290, 1293, 1930, 1931, 1932, 1933};
    clear_log();
    apply_stimulus(10, 1, 4, 3, 3, MODE_OUTLINE, s);
    wait_done(60, "outline");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 10) begin errors++; $display("[TB] FAIL outline_count got %0d want 10", wr_addr.size()); end
    for (int i = 0; i < 10; i++) begin
      got = (i < wr_addr.size()) ? wr_addr[i] : -1;
      checks++; if (got != exp_a[i]) begin errors++; $display("[TB] FAIL outline_addr%0d got %0d want %0d", i, got, exp_a[i]); end
      got = (i < wr_data.size()) ? wr_data[i] : -1;
      checks++; if (got != 3) begin errors++; $display("[TB] FAIL outline_data%0d got %0d want 3", i, got); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL outline_done_count got %0d want 1", done_cnt); end
  endtask

  task automatic test_clip();
    int s, got;
    int exp_o[7] = '{637, 638, 639, 1277, 1917, 1918, 1919};
    clear_log();
    apply_stimulus(638, 0, 4, 1, 2, MODE_FILL, s);
    wait_done(40, "clip_right");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 2) begin errors++; $display("[TB] FAIL clip_right_count got %0d want 2", wr_addr.size()); end
    got = (wr_addr.size() > 0) ? wr_addr[0] : -1;
    checks++; if (got != 638) begin errors++; $display("[TB] FAIL clip_right_addr0 got %0d want 638", got); end
    got = (wr_addr.size() > 1) ? wr_addr[1] : -1;
    checks++; if (got != 639) begin errors++; $display("[TB] FAIL clip_right_addr1 got %0d want 639", got); end

    clear_log();
    apply_stimulus(0, 479, 1, 3, 4, MODE_FILL, s);
    wait_done(40, "clip_bottom");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 1) begin errors++; $display("[TB] FAIL clip_bottom_count got %0d want 1", wr_addr.size()); end
    got = (wr_addr.size() > 0) ? wr_addr[0] : -1;
    checks++; if (got != 306560) begin errors++; $display("[TB] FAIL clip_bottom_addr got %0d want 306560", got); end

    // Outline whose right border lies off-screen: middle row keeps only its left pixel
    clear_log();
    apply_stimulus(637, 0, 5, 3, 1, MODE_OUTLINE, s);
    wait_done(40, "clip_outline");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 7) begin errors++; $display("[TB] FAIL clip_outline_count got %0d want 7", wr_addr.size()); end
    for (int i = 0; i < 7; i++) begin
      got = (i < wr_addr.size()) ? wr_addr[i] : -1;
      checks++; if (got != exp_o[i]) begin errors++; $display("[TB] FAIL clip_outline_addr%0d got %0d want %0d", i, got, exp_o[i]); end
    end
  endtask

  task automatic test_empty();
    int s;
    clear_log();
    apply_stimulus(5, 5, 0, 3, 1, MODE_FILL, s);
    wait_done(20, "empty_w0");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 0) begin errors++; $display("[TB] FAIL empty_w0_count got %0d want 0", wr_addr.size()); end
    checks++; if (done_cyc - s != 2) begin errors++; $display("[TB] FAIL empty_w0_done_time got %0d want 2", done_cyc - s); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL empty_w0_done_count got %0d want 1", done_cnt); end

    clear_log();
    apply_stimulus(640, 0, 4, 4, 1, MODE_FILL, s);
    wait_done(20, "empty_x640");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 0) begin errors++; $display("[TB] FAIL empty_x640_count got %0d want 0", wr_addr.size()); end
    checks++; if (done_cyc - s != 2) begin errors++; $display("[TB] FAIL empty_x640_done_time got %0d want 2", done_cyc - s); end
  endtask

  task automatic test_back_to_back();
    int s, s2, got;
    int exp_a[9] = '{3205, 3206, 3207, 3845, 3846, 3847, 4485, 4486, 4487};
    clear_log();
    apply_stimulus(5, 5, 3, 3, 6, MODE_FILL, s);
    // Stray starts while busy carry a different origin and must be ignored
    for (int i = 0; i < 3; i++) begin
      x = DIM_W'(100);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
    end
    wait_done(60, "b2b_first");
    apply_stimulus(0, 2, 2, 1, 6, MODE_FILL, s2);
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL b2b_done_count got %0d want 1", done_cnt); end
    checks++; if (wr_addr.size() != 9) begin errors++; $display("[TB] FAIL b2b_count got %0d want 9", wr_addr.size()); end
    for (int i = 0; i < 9; i++) begin
      got = (i < wr_addr.size()) ? wr_addr[i] : -1;
      checks++; if (got != exp_a[i]) begin errors++; $display("[TB] FAIL b2b_addr%0d got %0d want %0d", i, got, exp_a[i]); end
    end
    wait_done(40, "b2b_second");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 11) begin errors++; $display("[TB] FAIL b2b_total_count got %0d want 11", wr_addr.size()); end
    got = (wr_addr.size() > 9) ? wr_addr[9] : -1;
    checks++; if (got != 1280) begin errors++; $display("[TB] FAIL b2b_next_addr0 got %0d want 1280", got); end
    got = (wr_addr.size() > 10) ? wr_addr[10] : -1;
    checks++; if (got != 1281) begin errors++; $display("[TB] FAIL b2b_next_addr1 got %0d want 1281", got); end
    got = (wr_cyc.size() > 9) ? wr_cyc[9] - s2 : -1;
    checks++; if (got != 2) begin errors++; $display("[TB] FAIL b2b_next_latency got %0d want 2", got); end
    checks++; if (done_cnt != 2) begin errors++; $display("[TB] FAIL b2b_total_done got %0d want 2", done_cnt); end
  endtask

  task automatic test_reset_mid_draw();
    int s, k, n, seen_w, seen_d, got;
    clear_log();
    apply_stimulus(0, 10, 4, 4, 7, MODE_FILL, s);
    k = 0;
    n = 0;
    while (k < 3 && n < 30) begin
      @(negedge clock);
      n++;
      if (mem_wenable === 1'b1) k++;
    end
    checks++; if (k != 3) begin errors++; $display("[TB] FAIL abort_reach_third got %0d want 3", k); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (mem_wenable !== 1'b0) begin errors++; $display("[TB] FAIL abort_wen got %b want 0", mem_wenable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL abort_done got %b want 0", done); end
    checks++; if (mem_waddr !== '0) begin errors++; $display("[TB] FAIL abort_waddr got %0d want 0", mem_waddr); end
    seen_w = 0;
    seen_d = 0;
    repeat (12) begin
      @(negedge clock);
      if (mem_wenable === 1'b1) seen_w++;
      if (done === 1'b1) seen_d++;
    end
    checks++; if (seen_w != 0) begin errors++; $display("[TB] FAIL abort_late_writes got %0d want 0", seen_w); end
    checks++; if (seen_d != 0) begin errors++; $display("[TB] FAIL abort_late_done got %0d want 0", seen_d); end
    checks++; if (wr_addr.size() != 3) begin errors++; $display("[TB] FAIL abort_write_count got %0d want 3", wr_addr.size()); end
    got = (wr_addr.size() > 2) ? wr_addr[2] : -1;
    checks++; if (got != 6402) begin errors++; $display("[TB] FAIL abort_third_addr got %0d want 6402", got); end

    clear_log();
    apply_stimulus(0, 0, 2, 1, 1, MODE_FILL, s);
    wait_done(40, "after_abort");
    repeat (2) @(negedge clock);
    checks++; if (wr_addr.size() != 2) begin errors++; $display("[TB] FAIL after_abort_count got %0d want 2", wr_addr.size()); end
    got = (wr_addr.size() > 1) ? wr_addr[1] : -1;
    checks++; if (got != 1) begin errors++; $display("[TB] FAIL after_abort_addr1 got %0d want 1", got); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL after_abort_done got %0d want 1", done_cnt); end
  endtask

  initial begin
    $display("[TB] rect_draw_engine directed tests");
    test_reset();
    test_filled();
    test_outline();
    test_clip();
    test_empty();
    test_back_to_back();
    test_reset_mid_draw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
